fetch_pc_gen: RTL and testbench

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

---
 rtl/fetch_pc_gen.sv | 85 ++++++++
 tb/tb_fetch_pc_gen.sv | 131 +++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: exception > stall > redirect > pending redirect > sequential, one update per enabled edge.
// All outputs registered; a redirect seen during stall is parked and applied on the first unstalled edge.
module fetch_pc_gen #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h0040_0000),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0040_0004),
  parameter int                STEP      = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              ena_in,
  input  logic              stall_in,
  input  logic              exc_in,
  input  logic              redir_valid_in,
  input  logic [ADDR_W-1:0] redir_target_in,
  output logic [ADDR_W-1:0] pc_out,
  output logic              redir_pending_out,
  output logic              align_err_out,
  output logic [2:0]        epoch_out
);

  localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] ALIGN_M = ADDR_W'(STEP - 1);

  logic [ADDR_W-1:0] tgt_q;
  logic              mis_q;

  logic [ADDR_W-1:0] pc_d, tgt_d, app_tgt;
  logic              pend_d, mis_d, err_d, in_mis, app_mis;
  logic [2:0]        epoch_d;

  assign in_mis = |(redir_target_in & ALIGN_M);

  // A fresh redirect supersedes whatever is parked.
  assign app_tgt = redir_valid_in ? redir_target_in : tgt_q;
  assign app_mis = redir_valid_in ? in_mis : mis_q;

  always_comb begin
    pc_d    = pc_out;
    pend_d  = redir_pending_out;
    tgt_d   = tgt_q;
    mis_d   = mis_q;
    err_d   = 1'b0;
    epoch_d = epoch_out;
    if (ena_in) begin
      if (exc_in) begin
        pc_d    = EXC_VEC;
        pend_d  = 1'b0;
        epoch_d = epoch_out + 3'd1;
      end else if (stall_in) begin
        if (redir_valid_in) begin
          pend_d = 1'b1;
          tgt_d  = redir_target_in;
          mis_d  = in_mis;
        end
      end else if (redir_valid_in || redir_pending_out) begin
        pc_d    = app_mis ? EXC_VEC : app_tgt;
        err_d   = app_mis;
        pend_d  = 1'b0;
        epoch_d = epoch_out + 3'd1;
      end else begin
        pc_d = pc_out + STEP_V;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc_out            <= RESET_VEC;
      redir_pending_out <= 1'b0;
      tgt_q             <= '0;
      mis_q             <= 1'b0;
      align_err_out     <= 1'b0;
      epoch_out         <= 3'd0;
    end else begin
      pc_out            <= pc_d;
      redir_pending_out <= pend_d;
      tgt_q             <= tgt_d;
      mis_q             <= mis_d;
      align_err_out     <= err_d;
      epoch_out         <= epoch_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scoreboard bench for fetch_pc_gen: stimulus queues expected outputs, monitor checks after each edge or reset.
module tb_fetch_pc_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, ena = 1'b0, stall = 1'b0, exc = 1'b0, rv = 1'b0;
  logic [31:0] tgt = '0;
  logic [31:0] pc;
  logic        pend, err;
  logic [2:0]  ep;
  logic [7:0]  pc8;
  logic        pend8, err8;
  logic [2:0]  ep8;

  fetch_pc_gen dut (
    .clk_in(clk), .rst_in(rst), .ena_in(ena), .stall_in(stall), .exc_in(exc),
    .redir_valid_in(rv), .redir_target_in(tgt), .pc_out(pc),
    .redir_pending_out(pend), .align_err_out(err), .epoch_out(ep)
  );

  fetch_pc_gen #(.ADDR_W(8), .RESET_VEC(8'hF8), .EXC_VEC(8'h04), .STEP(4)) dut8 (
    .clk_in(clk), .rst_in(rst), .ena_in(1'b1), .stall_in(1'b0), .exc_in(1'b0),
    .redir_valid_in(1'b0), .redir_target_in(8'h00), .pc_out(pc8),
    .redir_pending_out(pend8), .align_err_out(err8), .epoch_out(ep8)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        pend;
    logic        err;
    logic [2:0]  ep;
    bit          chk8;
    logic [7:0]  pc8;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   compared = 0;
  int   mismatched = 0;

  // Monitor: one expectation is consumed after each clock edge or reset assertion.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        compared++;
        if (pc !== mon_e.pc || pend !== mon_e.pend || err !== mon_e.err || ep !== mon_e.ep ||
            (mon_e.chk8 && (pc8 !== mon_e.pc8 || pend8 !== 1'b0 || err8 !== 1'b0 || ep8 !== 3'd0))) begin
          mismatched++;
          $display("FAIL %s: got pc=%h pend=%b err=%b epoch=%0d pc8=%h; want pc=%h pend=%b err=%b epoch=%0d pc8=%h",
                   mon_e.name, pc, pend, err, ep, pc8, mon_e.pc, mon_e.pend, mon_e.err, mon_e.ep, mon_e.pc8);
        end
      end
    end
  end

  task automatic push(input string nm, input logic [31:0] xpc, input logic xpend, input logic xerr,
                      input logic [2:0] xep, input bit c8, input logic [7:0] p8);
    exp_t e;
    e.name = nm; e.pc = xpc; e.pend = xpend; e.err = xerr; e.ep = xep; e.chk8 = c8; e.pc8 = p8;
    q.push_back(e);
  endtask

  task automatic cyc(input string nm, input logic e, input logic s, input logic x, input logic r,
                     input logic [31:0] t, input logic [31:0] xpc, input logic xpend, input logic xerr,
                     input logic [2:0] xep, input bit c8 = 1'b0, input logic [7:0] p8 = 8'h00);
    @(negedge clk);
    rst = 1'b0; ena = e; stall = s; exc = x; rv = r; tgt = t;
    push(nm, xpc, xpend, xerr, xep, c8, p8);
  endtask

  // Reset is asserted between edges so the check sees it without any clock.
  task automatic do_reset(input string nm);
    @(negedge clk);
    push(nm, 32'h0040_0000, 1'b0, 1'b0, 3'd0, 1'b1, 8'hF8);
    rst = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    do_reset("reset");
    cyc("seq1", 1, 0, 0, 0, 32'h0, 32'h0040_0004, 0, 0, 0, 1'b1, 8'hFC);
    cyc("seq2", 1, 0, 0, 0, 32'h0, 32'h0040_0008, 0, 0, 0, 1'b1, 8'h00);
    cyc("seq3", 1, 0, 0, 0, 32'h0, 32'h0040_000C, 0, 0, 0, 1'b1, 8'h04);
    cyc("seq4", 1, 0, 0, 0, 32'h0, 32'h0040_0010, 0, 0, 0);
    cyc("redir_aligned", 1, 0, 0, 1, 32'h0040_0008, 32'h0040_0008, 0, 0, 1);
    cyc("stall_redir_a", 1, 1, 0, 1, 32'h0040_1000, 32'h0040_0008, 1, 0, 1);
    cyc("stall_redir_b", 1, 1, 0, 1, 32'h0040_2000, 32'h0040_0008, 1, 0, 1);
    cyc("pend_apply", 1, 0, 0, 0, 32'h0, 32'h0040_2000, 0, 0, 2);
    cyc("seq_after_apply", 1, 0, 0, 0, 32'h0, 32'h0040_2004, 0, 0, 2);
    cyc("stall_redir_c", 1, 1, 0, 1, 32'h0040_3000, 32'h0040_2004, 1, 0, 2);
    cyc("stall_exc", 1, 1, 1, 0, 32'h0, 32'h0040_0004, 0, 0, 3);
    cyc("release_no_pend", 1, 0, 0, 0, 32'h0, 32'h0040_0008, 0, 0, 3);
    cyc("misalign_redir", 1, 0, 0, 1, 32'h0040_1002, 32'h0040_0004, 0, 1, 4);
    cyc("err_pulse_end", 1, 0, 0, 0, 32'h0, 32'h0040_0008, 0, 0, 4);
    cyc("stall_mis", 1, 1, 0, 1, 32'h0040_5001, 32'h0040_0008, 1, 0, 4);
    cyc("pend_mis_apply", 1, 0, 0, 0, 32'h0, 32'h0040_0004, 0, 1, 5);
    cyc("seq_after_mis", 1, 0, 0, 0, 32'h0, 32'h0040_0008, 0, 0, 5);
    cyc("stall_mis_b", 1, 1, 0, 1, 32'h0040_1003, 32'h0040_0008, 1, 0, 5);
    cyc("stall_overwrite", 1, 1, 0, 1, 32'h0040_6000, 32'h0040_0008, 1, 0, 5);
    cyc("overwrite_apply", 1, 0, 0, 0, 32'h0, 32'h0040_6000, 0, 0, 6);
    cyc("exc_over_redir", 1, 0, 1, 1, 32'h0040_7000, 32'h0040_0004, 0, 0, 7);
    cyc("seq_after_exc", 1, 0, 0, 0, 32'h0, 32'h0040_0008, 0, 0, 7);
    cyc("epoch_wrap", 1, 0, 0, 1, 32'h0040_8000, 32'h0040_8000, 0, 0, 0);
    cyc("ena0_a", 0, 0, 1, 1, 32'h0040_9001, 32'h0040_8000, 0, 0, 0);
    cyc("ena0_b", 0, 0, 1, 1, 32'h0040_9001, 32'h0040_8000, 0, 0, 0);
    cyc("ena_resume", 1, 0, 0, 0, 32'h0, 32'h0040_8004, 0, 0, 0);
    cyc("stall_redir_d", 1, 1, 0, 1, 32'h0040_A000, 32'h0040_8004, 1, 0, 0);
    cyc("ena0_hold_pend", 0, 0, 0, 0, 32'h0, 32'h0040_8004, 1, 0, 0);
    cyc("ena_pend_apply", 1, 0, 0, 0, 32'h0, 32'h0040_A000, 0, 0, 1);
    cyc("wrap_redir", 1, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 2);
    cyc("pc_wrap", 1, 0, 0, 0, 32'h0, 32'h0000_0000, 0, 0, 2);
    cyc("stall_redir_e", 1, 1, 0, 1, 32'h0040_B000, 32'h0000_0000, 1, 0, 2);
    do_reset("reset_mid_stall");
    cyc("post_reset1", 1, 0, 0, 0, 32'h0, 32'h0040_0004, 0, 0, 0, 1'b1, 8'hFC);
    cyc("post_reset2", 1, 0, 0, 0, 32'h0, 32'h0040_0008, 0, 0, 0, 1'b1, 8'h00);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
